// File: rtl/i2s_pkg.sv
// Shared I2S constants for the receiver and transmitter.
package i2s_pkg;

  localparam logic I2S_WS_LEFT  = 1'b0;
  localparam logic I2S_WS_RIGHT = 1'b1;

  localparam int unsigned I2S_DATA_W_DEFAULT      = 32;
  localparam int unsigned I2S_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-bit input synchroniser with a registered rising-edge pulse on bit 0.
// Bits WIDTH-1:1 are delayed one extra flop so they stay aligned with rise.
module i2s_sync_edge
  import i2s_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = I2S_SYNC_STAGES_DEFAULT,
  parameter int unsigned WIDTH       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:1] sync,
  output logic             rise
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic             last;

  // Synchroniser chain, edge detect on bit 0, aligned copy of the other bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        chain[i] <= '0;
      end
      last <= 1'b0;
      rise <= 1'b0;
      sync <= '0;
    end else begin
      chain[0] <= pins;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      last <= chain[SYNC_STAGES-1][0];
      rise <= chain[SYNC_STAGES-1][0] & ~last;
      sync <= chain[SYNC_STAGES-1][WIDTH-1:1];
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips) slave receiver: oversamples sclk/lrclk/sdata on mclk and
// publishes each completed left/right word, left-justified, with a 1-cycle strobe.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = I2S_DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = I2S_SYNC_STAGES_DEFAULT
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              lrclk,
  input  logic              sdata,
  output logic [DATA_W-1:0] l_dout,
  output logic [DATA_W-1:0] r_dout,
  output logic              l_valid,
  output logic              r_valid,
  output logic              short_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic              bit_stb;
  logic [2:1]        pin_sync;
  logic              ws;
  logic              d;

  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_ins;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_ins;
  logic              armed;
  logic              ws_prev;

  i2s_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (3)
  ) u_sync (
    .clk   (mclk),
    .rst_n (rst_n),
    .pins  ({sdata, lrclk, sclk}),
    .sync  (pin_sync),
    .rise  (bit_stb)
  );

  assign ws = pin_sync[1];
  assign d  = pin_sync[2];

  // Shift register and count after storing the current bit (saturating at DATA_W).
  always_comb begin
    shreg_ins = shreg;
    cnt_ins   = cnt;
    if (cnt < CNT_W'(DATA_W)) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (cnt == CNT_W'(DATA_W - 1 - i)) begin
          shreg_ins[i] = d;
        end
      end
      cnt_ins = cnt + CNT_W'(1);
    end
  end

  // Bit accumulation, word-boundary publish and arming.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      shreg   <= '0;
      cnt     <= '0;
      armed   <= 1'b0;
      ws_prev <= 1'b0;
      l_dout  <= '0;
      r_dout  <= '0;
      l_valid <= 1'b0;
      r_valid <= 1'b0;
      short_o <= 1'b0;
    end else begin
      l_valid <= 1'b0;
      r_valid <= 1'b0;
      short_o <= 1'b0;
      if (bit_stb) begin
        ws_prev <= ws;
        if (ws == ws_prev) begin
          shreg <= shreg_ins;
          cnt   <= cnt_ins;
        end else begin
          // The boundary bit is the LSB slot of the word that just ended.
          if (armed) begin
            if (ws_prev == I2S_WS_LEFT) begin
              l_dout  <= shreg_ins;
              l_valid <= 1'b1;
            end else begin
              r_dout  <= shreg_ins;
              r_valid <= 1'b1;
            end
            short_o <= (cnt_ins < CNT_W'(DATA_W));
          end
          shreg <= '0;
          cnt   <= '0;
          armed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Testbench for i2s_rx: drives Philips I2S frames and checks both a 32-bit and
// a 24-bit receiver against a word-level reference model.
module tb_i2s_rx;

  logic        mclk  = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk  = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;

  logic [31:0] l32, r32;
  logic        lv32, rv32, s32;
  logic [23:0] l24, r24;
  logic        lv24, rv24, s24;

  int          checks = 0;
  int          passed = 0;
  int          viol   = 0;
  int unsigned cyc    = 0;
  int          half   = 4;
  bit          armed_m = 1'b0;
  logic        rst_q  = 1'b0;

  typedef struct {
    logic        ch;
    logic [31:0] w;
    logic        s;
    int unsigned cyc;
  } pulse_t;

  pulse_t q32[$], q24[$], exp32[$], exp24[$];

  i2s_rx #(.DATA_W(32), .SYNC_STAGES(2)) dut32 (
    .mclk (mclk), .rst_n (rst_n), .sclk (sclk), .lrclk (lrclk), .sdata (sdata),
    .l_dout (l32), .r_dout (r32), .l_valid (lv32), .r_valid (rv32), .short_o (s32)
  );

  i2s_rx #(.DATA_W(24), .SYNC_STAGES(2)) dut24 (
    .mclk (mclk), .rst_n (rst_n), .sclk (sclk), .lrclk (lrclk), .sdata (sdata),
    .l_dout (l24), .r_dout (r24), .l_valid (lv24), .r_valid (rv24), .short_o (s24)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  // Pulse recorder plus protocol watchdog (overlap, width, stray short, hold).
  logic        plv32 = 1'b0, prv32 = 1'b0, plv24 = 1'b0, prv24 = 1'b0;
  logic [31:0] pl32, pr32;
  logic [23:0] pl24, pr24;
  always @(negedge mclk) begin
    if (lv32 && rv32) viol++;
    if ((lv32 && plv32) || (rv32 && prv32)) viol++;
    if (s32 && !lv32 && !rv32) viol++;
    if (rst_q && !lv32 && (l32 !== pl32)) viol++;
    if (rst_q && !rv32 && (r32 !== pr32)) viol++;
    if (lv24 && rv24) viol++;
    if ((lv24 && plv24) || (rv24 && prv24)) viol++;
    if (s24 && !lv24 && !rv24) viol++;
    if (rst_q && !lv24 && (l24 !== pl24)) viol++;
    if (rst_q && !rv24 && (r24 !== pr24)) viol++;
    if (lv32) q32.push_back('{ch: 1'b0, w: l32, s: s32, cyc: cyc});
    if (rv32) q32.push_back('{ch: 1'b1, w: r32, s: s32, cyc: cyc});
    if (lv24) q24.push_back('{ch: 1'b0, w: {l24, 8'h00}, s: s24, cyc: cyc});
    if (rv24) q24.push_back('{ch: 1'b1, w: {r24, 8'h00}, s: s24, cyc: cyc});
    plv32 = lv32; prv32 = rv32; pl32 = l32; pr32 = r32;
    plv24 = lv24; prv24 = rv24; pl24 = l24; pr24 = r24;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One sclk period: lrclk/sdata change with the falling edge, sampled on the rise.
  task automatic sclk_bit(input logic ws, input logic d, output int unsigned rc);
    @(posedge mclk); #1;
    sclk = 1'b0; lrclk = ws; sdata = d;
    repeat (half) @(posedge mclk);
    #1 sclk = 1'b1;
    rc = cyc;
    repeat (half - 1) @(posedge mclk);
  endtask

  // Expected result of a finished word: first min(slot,W) bits, left-justified.
  task automatic model_word(input logic ch, input int slot, input logic [31:0] data,
                            input int unsigned rc);
    logic [31:0] m;
    m = (slot >= 32) ? data : ((data >> (32 - slot)) << (32 - slot));
    if (armed_m) begin
      exp32.push_back('{ch: ch, w: m, s: (slot < 32), cyc: rc + 4});
      exp24.push_back('{ch: ch, w: {m[31:8], 8'h00}, s: (slot < 24), cyc: rc + 4});
    end
    armed_m = 1'b1;
  endtask

  // Sends slot bits [first,last) of a word; ws flips one bit early (on the LSB).
  task automatic send_part(input logic ch, input logic nxt, input int slot,
                           input logic [31:0] data, input int first, input int last);
    int unsigned rc;
    rc = 0;
    for (int k = first; k < last; k++) begin
      sclk_bit((k == slot - 1) ? nxt : ch, data[5'(31 - k)], rc);
    end
    if (last == slot) model_word(ch, slot, data, rc);
  endtask

  task automatic send_word(input logic ch, input logic nxt, input int slot,
                           input logic [31:0] data);
    send_part(ch, nxt, slot, data, 0, slot);
  endtask

  task automatic check_pulses(input string tag);
    repeat (12) @(posedge mclk);
    #1;
    chk({tag, " n32"}, 64'(q32.size()), 64'(exp32.size()));
    for (int i = 0; i < q32.size() && i < exp32.size(); i++) begin
      chk({tag, " ch32"}, 64'(q32[i].ch), 64'(exp32[i].ch));
      chk({tag, " w32"}, 64'(q32[i].w), 64'(exp32[i].w));
      chk({tag, " short32"}, 64'(q32[i].s), 64'(exp32[i].s));
      chk({tag, " lat32"}, 64'(q32[i].cyc), 64'(exp32[i].cyc));
    end
    chk({tag, " n24"}, 64'(q24.size()), 64'(exp24.size()));
    for (int i = 0; i < q24.size() && i < exp24.size(); i++) begin
      chk({tag, " ch24"}, 64'(q24[i].ch), 64'(exp24[i].ch));
      chk({tag, " w24"}, 64'(q24[i].w), 64'(exp24[i].w));
      chk({tag, " short24"}, 64'(q24[i].s), 64'(exp24[i].s));
    end
    chk({tag, " protocol"}, 64'(viol), 64'(0));
    q32.delete(); q24.delete(); exp32.delete(); exp24.delete();
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] hold_l;

    // Reset state
    repeat (3) @(posedge mclk);
    #1;
    chk("rst l_dout", 64'(l32), 64'(0));
    chk("rst r_dout", 64'(r32), 64'(0));
    chk("rst l_valid", 64'(lv32), 64'(0));
    chk("rst r_valid", 64'(rv32), 64'(0));
    chk("rst short", 64'(s32), 64'(0));
    chk("rst l_dout24", 64'(l24), 64'(0));
    rst_n = 1'b1;
    armed_m = 1'b0;

    // Two full 64-sclk frames; the first left word only arms the block
    half = 4;
    repeat (2) begin
      send_word(1'b0, 1'b1, 32, 32'hA5A5_0F0F);
      send_word(1'b1, 1'b0, 32, 32'h1234_5678);
    end
    check_pulses("frame");
    chk("frame l_dout", 64'(l32), 64'h0000_0000_A5A5_0F0F);
    chk("frame r_dout", 64'(r32), 64'h0000_0000_1234_5678);

    // 24-bit data in 32-bit slots with trailing zeros
    send_word(1'b0, 1'b1, 32, {24'hABCDEF, 8'h00});
    send_word(1'b1, 1'b0, 32, $urandom);
    check_pulses("w24");
    chk("w24 l_dout24", 64'(l24), 64'h00AB_CDEF);

    // 16-bit slots (32-sclk frame)
    send_word(1'b0, 1'b1, 16, {16'hBEEF, 16'h0000});
    send_word(1'b1, 1'b0, 16, {16'h1357, 16'h0000});
    check_pulses("w16");
    chk("w16 l_dout", 64'(l32), 64'h0000_0000_BEEF_0000);

    // Reset pulse mid left word: partial word discarded, re-arm at next boundary
    d = $urandom;
    send_part(1'b0, 1'b1, 32, d, 0, 10);
    @(posedge mclk); #1 rst_n = 1'b0;
    @(posedge mclk); #1 rst_n = 1'b1;
    chk("midrst l_dout", 64'(l32), 64'(0));
    chk("midrst r_dout", 64'(r32), 64'(0));
    chk("midrst r_dout24", 64'(r24), 64'(0));
    armed_m = 1'b0;
    send_part(1'b0, 1'b1, 32, d, 10, 32);
    send_word(1'b1, 1'b0, 32, $urandom);
    check_pulses("midrst");

    // Minimum sclk ratio, random data
    half = 2;
    repeat (100) begin
      send_word(1'b0, 1'b1, 32, $urandom);
      send_word(1'b1, 1'b0, 32, $urandom);
    end
    check_pulses("random");

    // sclk stalled mid-word for 1000 mclk
    half = 3;
    d = $urandom;
    hold_l = l32;
    send_part(1'b0, 1'b1, 32, d, 0, 15);
    repeat (1000) @(posedge mclk);
    #1;
    chk("stall pulses", 64'(q32.size()), 64'(0));
    chk("stall l_hold", 64'(l32), 64'(hold_l));
    send_part(1'b0, 1'b1, 32, d, 15, 32);
    send_word(1'b1, 1'b0, 32, $urandom);
    check_pulses("stall");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
